add_seq: RTL and testbench
==========================

Name: add_seq

Overview:
- Multi-cycle wide adder/subtractor controller that time-shares a single 4-bit carry-lookahead slice across all nibbles of a WIDTH-bit operand pair.
- Processes one nibble per clock, LSB first, and chains the carry through a register.
- Sits beside the ALU as a low-area arithmetic engine for wide operations, with a start/done handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = A+B+cin; 1 = A−B (B inverted, carry-in forced to 1, cin ignored).
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- cin  input  1  carry-in for add; captured when start is accepted.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, nibble index=0, carry reg=0.
- Reset mid-operation (any state) aborts the operation. The next cycle is IDLE with all outputs at their reset values.
- State IDLE:
  - On start=1: latch a into A reg; latch b into B reg, or ~b if sub=1.
  - Carry reg <= sub ? 1 : cin. Index <= 0. Go to RUN.
  - sum, cout, ovf and zero hold their previous values until the new result is written.
- State RUN: each clock edge does the following.
  - Feed nibble[idx] of A reg and B reg plus the carry reg to the slice.
  - Write the slice sum into sum[4*idx+3:4*idx].
  - Carry reg <= slice group-generate output (GG includes the Cin term, so it equals the nibble carry-out).
  - idx <= idx+1.
- Last nibble (idx == NIB−1) edge, in addition:
  - cout <= GG.
  - ovf <= (A_msb == B'_msb) & (slice S[3] != A_msb), where B' is the possibly inverted operand.
  - zero <= (upper nibble result == 0) & (all lower result nibbles == 0).
  - State <= DONE.
- State DONE: done=1 and busy=1 for exactly one cycle, then go unconditionally to IDLE. start is ignored in DONE.
- Latency: if start is sampled at edge E0, done is high in the cycle after edge E0+NIB (WIDTH=16: done is visible 4 cycles after the start edge). Throughput is one operation per NIB+2 cycles.
- start asserted while busy=1 is ignored; it is neither queued nor allowed to corrupt the operation.
- Changes to a, b, cin or sub after acceptance have no effect on the running operation.
- Outputs sum, cout, ovf and zero remain stable after done until the next accepted start begins overwriting them. sum nibbles update progressively during RUN.
- Index counter width is clog2(NIB); it never wraps past NIB−1 because the FSM leaves RUN at that value.

Decomposition:
- Shared package arith_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - NIB_W = 4 constant;
  - function computing the index width from WIDTH.
- One sub-module: add4, the existing 4-bit CLA slice (A, B, Cin -> S, PG, GG), instantiated once. PG is left unused.
- The controller, operand registers, carry register and result assembly live in add_seq.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, sub=0, cin=0, start pulse -> after 4 cycles done=1, sum=0x5555, cout=0, ovf=0, zero=0; busy high 5 cycles.
- a=0x0F0F, b=0x00F1, cin=1 -> sum=0x1001, cout=0 (carry chain across nibbles 0->1->2).
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0; then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0.
- sub=1, a=0x0005, b=0x0007, cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0; sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Start op 0x1111+0x2222; pulse start with 0xAAAA+0x5555 during RUN; assert rst on a later op at idx=2 -> first result 0x3333 unaffected by the second start; after rst all outputs 0 and busy=0 next cycle; the following op 0x0001+0x0001 returns 0x0002.
- Randomized back-to-back ops with a, b, sub, cin changed every cycle after acceptance -> each result equals a reference a±b captured at the start edge; exactly one done per accepted start.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and helpers for the nibble-serial arithmetic engine
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  // Width of the nibble index for a given operand width (at least one bit).
  function automatic int idx_width(input int width);
    int n;
    n = width / NIB_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_seq_if.sv
// rtl/add_seq_if.sv - start/done handshake and operand/result bundle for add_seq
interface add_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/add4.sv
// rtl/add4.sv - 4-bit carry-lookahead slice; o_gg folds in i_cin so it equals the carry-out
module add4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_pg,
  output logic       o_gg
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_s  = w_p ^ w_c;
  assign o_pg = &w_p;
  assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | ((&w_p) & i_cin);
endmodule

// File: rtl/add_seq.sv
// rtl/add_seq.sv - wide add/sub that reuses one add4 slice, one nibble per clock, LSB first
module add_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  add_seq_if.slave bus
);
  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [3:0] w_s;
  logic       w_gg;

  assign w_a_nib = r_a[NIB_W*r_idx +: NIB_W];
  assign w_b_nib = r_b[NIB_W*r_idx +: NIB_W];

  add4 u_add4 (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_cin(r_carry),
    .o_s  (w_s),
    .o_pg (),
    .o_gg (w_gg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1; cin is deliberately ignored then.
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[NIB_W*r_idx +: NIB_W] <= w_s;
          r_carry <= w_gg;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_gg;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
            r_zero  <= (w_s == 4'd0) && (r_sum[WIDTH-NIB_W-1:0] == '0);
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;
endmodule

// File: tb/tb_add_seq.sv
// tb/tb_add_seq.sv - directed and randomized checks of add_seq at WIDTH=16
module tb_add_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;
  int   n_ops;

  add_seq_if #(.WIDTH(16)) bus ();

  add_seq #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.sub   = 1'($urandom);
    bus.cin   = 1'($urandom);
    bus.start = 1'($urandom);
  endtask

  // mode 0: quiet, 1: one intruding start 0xAAAA+0x5555 during RUN, 2: random input churn
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                       input logic [15:0] es, input logic ec, input logic eo, input logic ez,
                       input int mode, input string tag);
    int cyc;
    int busy_cnt;
    logic seen;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (mode == 1) begin
      bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    end else if (mode == 2) begin
      scramble();
    end
    n_ops++;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (cyc < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
      if (mode == 1) bus.start = 1'b0;
      else if (mode == 2) scramble();
    end
    bus.start = 1'b0;
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'd4);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, ".sum"}, 32'(bus.sum), 32'(es));
    check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, ".zero"}, 32'(bus.zero), 32'(ez));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".idle_after"}, 32'(bus.busy), 32'd0);
    check({tag, ".sum_hold"}, 32'(bus.sum), 32'(es));
  endtask

  initial begin
    logic [15:0] ra, rb, rbp;
    logic        rs, rc;
    logic [16:0] full;
    checks = 0; errors = 0; done_cnt = 0; n_ops = 0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.sum", 32'(bus.sum), 32'd0);
    check("reset.flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    rst = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0, "add_basic");
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 0, "add_chain");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, "add_wrap_zero");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0, "add_ovf");
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0, "sub_borrow");
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0, "sub_ovf");
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1, "start_while_busy");

    // Abort an operation once the index has reached 2.
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.sum", 32'(bus.sum), 32'd0);
    check("abort.flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0, "after_abort");

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      rbp  = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, rbp} + 17'(rs ? 1'b1 : rc);
      do_op(ra, rb, rs, rc, full[15:0], full[16],
            (ra[15] == rbp[15]) && (full[15] != ra[15]), full[15:0] == 16'h0000,
            2, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(n_ops));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
